// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO; frames are sent back-to-back
// while bytes are queued. Bit period is CLK/UART_BPS system clocks.
module uart_tx #(
  parameter int CLK        = 50000000,
  parameter int UART_BPS   = 921600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] in_data,
  input  logic       in_flag,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int BPS_CNT = CLK / UART_BPS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]   BAUD_LAST = 32'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   baud_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic          tick, pop, push;

  assign tick = (baud_q == BAUD_LAST);
  // Pops only from the registered count, so a fresh write never bypasses to the shifter.
  assign pop  = (cnt_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && tick));
  assign push = in_flag && ((cnt_q != CNT_MAX) || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      baud_q    <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q     <= cnt_d;
      fifo_full <= (cnt_d == CNT_MAX);
      overflow  <= in_flag && !push;
      // Drops on the very edge that enters IDLE with nothing left to send.
      tx_busy   <= !(((state_q == IDLE) || ((state_q == STOP) && tick)) && !pop);
      if (state_q != IDLE) baud_q <= tick ? '0 : baud_q + 32'd1;

      case (state_q)
        IDLE: if (pop) begin
          shift_q <= mem_q[rd_ptr_q];
          tx      <= 1'b0;
          baud_q  <= '0;
          state_q <= START;
        end
        START: if (tick) begin
          tx      <= shift_q[0];
          bit_q   <= '0;
          state_q <= DATA;
        end
        DATA: if (tick) begin
          if (bit_q == 3'd7) begin
            tx      <= 1'b1;
            state_q <= STOP;
          end else begin
            shift_q <= shift_q >> 1;
            tx      <= shift_q[1];
            bit_q   <= bit_q + 3'd1;
          end
        end
        STOP: if (tick) begin
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            tx      <= 1'b0;
            state_q <= START;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a line monitor decodes frames at exact bit timing
// and checks them against a scoreboard of accepted bytes.
module tb_uart_tx;
  localparam int BPS = 54;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_flag = 1'b0;
  logic       tx, tx_busy, fifo_full, overflow;
  logic [7:0] in_data2 = '0;
  logic       in_flag2 = 1'b0;
  logic       tx2, busy2, full2, ovf2;

  uart_tx dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(in_data), .in_flag(in_flag),
    .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  uart_tx #(.CLK(1000), .UART_BPS(100)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(in_data2), .in_flag(in_flag2),
    .tx(tx2), .tx_busy(busy2), .fifo_full(full2), .overflow(ovf2)
  );

  always #10 sys_clk = ~sys_clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         starts[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor: every clock of the frame must match the expected level.
  bit         mon_act = 1'b0;
  int         mon_cyc = 0;
  logic [9:0] mon_exp = '0;
  logic [7:0] mon_got = '0;
  bit         mon_bad = 1'b0;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1; mon_cyc = 0; mon_bad = 1'b0; mon_got = '0;
        starts.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          mon_exp = 10'h200;
        end else begin
          mon_exp = {1'b1, sb.pop_front(), 1'b0};
        end
      end
    end else begin
      mon_cyc++;
      if (tx !== mon_exp[mon_cyc / BPS]) mon_bad = 1'b1;
      if ((mon_cyc % BPS == BPS / 2) && (mon_cyc / BPS inside {[1:8]}))
        mon_got[mon_cyc / BPS - 1] = tx;
      if (mon_cyc == 10 * BPS - 1) begin
        chk("frame_data", {23'd0, mon_bad, mon_got}, {24'd0, mon_exp[8:1]});
        mon_act = 1'b0;
      end
    end
  end

  int busy_run = 0, last_run = 0, ovf_cnt = 0;
  always @(negedge sys_clk) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (tx_busy === 1'b1) busy_run++;
    else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic strobe(input logic [7:0] b, input bit acc);
    in_flag = 1'b1; in_data = b;
    if (acc) sb.push_back(b);
    @(negedge sys_clk);
    in_flag = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((tx_busy !== 1'b0 || mon_act || sb.size() != 0) && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, 32'(n < 20000), 32'd1);
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int o0, low, bad;
    repeat (3) @(negedge sys_clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Single byte: tx falls one edge after the strobe edge
    strobe(8'h55, 1'b1);
    chk("lat_tx_hold", 32'(tx), 32'd1);
    chk("lat_busy_lo", 32'(tx_busy), 32'd0);
    @(negedge sys_clk);
    chk("lat_tx_fall", 32'(tx), 32'd0);
    chk("lat_busy_hi", 32'(tx_busy), 32'd1);
    @(negedge sys_clk);
    wait_idle("idle_single");
    chk("busy_single", 32'(last_run), 32'd540);

    // Back-to-back frames
    starts.delete();
    strobe(8'hA5, 1'b1);
    strobe(8'h3C, 1'b1);
    repeat (2) @(negedge sys_clk);
    wait_idle("idle_b2b");
    chk("b2b_frames", 32'(starts.size()), 32'd2);
    chk("b2b_gap", 32'((starts.size() >= 2) ? starts[1] - starts[0] : 0), 32'd540);
    chk("busy_b2b", 32'(last_run), 32'd1080);

    // Overflow: sixth byte dropped
    o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) strobe(8'(i), 1'b1);
    strobe(8'h06, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_full", 32'(fifo_full), 32'd1);
    @(negedge sys_clk);
    chk("ovf_one_cycle", 32'(overflow), 32'd0);
    chk("ovf_full_hold", 32'(fifo_full), 32'd1);
    repeat (540) @(negedge sys_clk);
    chk("ovf_full_drop", 32'(fifo_full), 32'd0);
    wait_idle("idle_ovf");
    chk("ovf_count", 32'(ovf_cnt - o0), 32'd1);

    // Full FIFO, write on the last stop-bit clock alongside a pop
    o0 = ovf_cnt;
    strobe(8'h11, 1'b1);
    for (int i = 0; i < 4; i++) strobe(8'(8'h21 + i), 1'b1);
    repeat (536) @(negedge sys_clk);
    chk("pop_full_before", 32'(fifo_full), 32'd1);
    strobe(8'h77, 1'b1);
    chk("pop_no_ovf", 32'(overflow), 32'd0);
    chk("pop_full_after", 32'(fifo_full), 32'd1);
    wait_idle("idle_pop");
    chk("pop_ovf_count", 32'(ovf_cnt - o0), 32'd0);

    // Reset during data bit 3 with two bytes queued
    strobe(8'h81, 1'b1);
    strobe(8'h82, 1'b1);
    strobe(8'h83, 1'b1);
    repeat (240) @(negedge sys_clk);
    chk("mid_busy", 32'(tx_busy), 32'd1);
    #3 sys_rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_busy", 32'(tx_busy), 32'd0);
    chk("arst_full", 32'(fifo_full), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    low = 0;
    repeat (1200) begin
      @(negedge sys_clk);
      if (tx !== 1'b1) low++;
    end
    chk("rst_quiet", 32'(low), 32'd0);
    chk("rst_quiet_busy", 32'(tx_busy), 32'd0);
    strobe(8'h5A, 1'b1);
    @(negedge sys_clk);
    wait_idle("idle_after_rst");

    // Alternate baud: 10-clock bits
    in_flag2 = 1'b1; in_data2 = 8'hFF;
    @(negedge sys_clk);
    in_flag2 = 1'b0;
    chk("baud_lat", 32'(tx2), 32'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (tx2 !== ((i < 10) ? 1'b0 : 1'b1)) bad++;
    end
    chk("baud_frame", 32'(bad), 32'd0);
    @(negedge sys_clk);
    chk("baud_busy_end", 32'(busy2), 32'd0);
    chk("baud_flags", {30'd0, full2, ovf2}, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
